// File: rtl/obstacle_lane_ctrl.sv
// Scrolling obstacle engine: N channels moving left, LFSR respawn, collision, score pulses, IDLE/RUN/CRASH FSM.
// Optional macro SPEEDUP_EN: score counter that raises the per-tick step every SPEEDUP_EVERY points.
module obstacle_lane_ctrl #(
    parameter int unsigned NUM_OBS       = 3,
    parameter int unsigned X_W           = 11,
    parameter int unsigned Y_W           = 9,
    parameter int unsigned SCREEN_W      = 640,
    parameter int unsigned SPACING       = 220,
    parameter int unsigned STEP          = 2,
    parameter int unsigned OBS_W         = 40,
    parameter int unsigned OBS_H         = 60,
    parameter int unsigned PLAYER_X      = 100,
    parameter int unsigned PLAYER_W      = 20,
    parameter int unsigned PLAYER_H      = 20,
    parameter int unsigned Y_MAX         = 400,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter int unsigned SPEEDUP_EVERY = 8,
    parameter int unsigned STEP_MAX      = 6
) (
    input  logic                     iClk,
    input  logic                     iReset,
    input  logic                     iStart,
    input  logic                     iTick,
    input  logic [Y_W-1:0]           iPlayerY,
    output logic [NUM_OBS*X_W-1:0]   oPosX,
    output logic [NUM_OBS*Y_W-1:0]   oPosY,
    output logic                     oPaint,
    output logic                     oScorePulse,
    output logic                     oCrash,
    output logic [1:0]               oState
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CRASH = 2'd2
    } state_t;

    state_t          r_state;
    logic [15:0]     r_lfsr;
    logic [X_W-1:0]  r_x [NUM_OBS];
    logic [Y_W-1:0]  r_y [NUM_OBS];
    logic            r_paint;
    logic            r_crash;
    logic            r_pulse;

    logic [X_W-1:0]  w_step;
    logic [X_W-1:0]  w_x_next [NUM_OBS];
    logic [NUM_OBS-1:0] w_wrap;
    logic [NUM_OBS-1:0] w_pass;
    logic [NUM_OBS-1:0] w_hit;
    logic [Y_W-1:0]  w_respawn_y;
    logic            w_lfsr_fb;

    function automatic logic [X_W-1:0] init_x(input int unsigned idx);
        return X_W'(SCREEN_W + idx * SPACING);
    endfunction

`ifdef SPEEDUP_EN
    logic [7:0]      r_score;
    logic [X_W-1:0]  r_step;
    logic [7:0]      w_score_inc;
    assign w_step      = r_step;
    assign w_score_inc = r_score + 8'd1;
`else
    assign w_step = X_W'(STEP);
`endif

    assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_respawn_y = (r_lfsr[Y_W-1:0] > Y_W'(Y_MAX)) ? Y_W'(Y_MAX) : r_lfsr[Y_W-1:0];

    // All edge/overlap sums carry one extra bit so they cannot wrap.
    always_comb begin
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            w_wrap[i]   = r_x[i] < w_step;
            w_x_next[i] = w_wrap[i]
                ? X_W'({1'b0, r_x[i]} + (X_W+1)'(NUM_OBS * SPACING) - {1'b0, w_step})
                : r_x[i] - w_step;
            w_pass[i]   = (({1'b0, r_x[i]} + (X_W+1)'(OBS_W)) >= (X_W+1)'(PLAYER_X))
                       && (({1'b0, w_x_next[i]} + (X_W+1)'(OBS_W)) < (X_W+1)'(PLAYER_X));
            w_hit[i]    = ({1'b0, r_x[i]} < (X_W+1)'(PLAYER_X + PLAYER_W))
                       && (({1'b0, r_x[i]} + (X_W+1)'(OBS_W)) > (X_W+1)'(PLAYER_X))
                       && ({1'b0, r_y[i]} < ({1'b0, iPlayerY} + (Y_W+1)'(PLAYER_H)))
                       && (({1'b0, r_y[i]} + (Y_W+1)'(OBS_H)) > {1'b0, iPlayerY});
        end
    end

    always_ff @(posedge iClk or posedge iReset) begin
        if (iReset) begin
            r_state <= S_IDLE;
            r_lfsr  <= LFSR_SEED;
            r_paint <= 1'b0;
            r_crash <= 1'b0;
            r_pulse <= 1'b0;
            for (int unsigned i = 0; i < NUM_OBS; i++) begin
                r_x[i] <= init_x(i);
                r_y[i] <= Y_W'(Y_MAX >> 1);
            end
`ifdef SPEEDUP_EN
            r_score <= '0;
            r_step  <= X_W'(STEP);
`endif
        end else begin
            r_lfsr  <= {r_lfsr[14:0], w_lfsr_fb};
            r_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (iStart) begin
                        r_state <= S_RUN;
                        r_paint <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A collision freezes the lane and swallows any same-clock score.
                    if (|w_hit) begin
                        r_state <= S_CRASH;
                        r_crash <= 1'b1;
                    end else if (iTick) begin
                        r_pulse <= |w_pass;
                        for (int unsigned i = 0; i < NUM_OBS; i++) begin
                            r_x[i] <= w_x_next[i];
                            if (w_wrap[i])
                                r_y[i] <= w_respawn_y;
                        end
`ifdef SPEEDUP_EN
                        if (|w_pass) begin
                            r_score <= w_score_inc;
                            if ((w_score_inc % 8'(SPEEDUP_EVERY)) == 8'd0 && r_step < X_W'(STEP_MAX))
                                r_step <= r_step + X_W'(1);
                        end
`endif
                    end
                end
                S_CRASH: begin
                    if (iStart) begin
                        r_state <= S_IDLE;
                        r_paint <= 1'b0;
                        r_crash <= 1'b0;
                        for (int unsigned i = 0; i < NUM_OBS; i++) begin
                            r_x[i] <= init_x(i);
                            r_y[i] <= Y_W'(Y_MAX >> 1);
                        end
`ifdef SPEEDUP_EN
                        r_score <= '0;
                        r_step  <= X_W'(STEP);
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        oPosX = '0;
        oPosY = '0;
        for (int unsigned i = 0; i < NUM_OBS; i++) begin
            oPosX[i*X_W +: X_W] = r_x[i];
            oPosY[i*Y_W +: Y_W] = r_y[i];
        end
    end

    assign oPaint      = r_paint;
    assign oCrash      = r_crash;
    assign oScorePulse = r_pulse;
    assign oState      = r_state;

endmodule

// File: doc/obstacle_lane_ctrl.md
Name: obstacle_lane_ctrl

Overview:
- Parametrised obstacle engine for the car/bird game: holds NUM_OBS scrolling obstacles, moves them left on each movement tick and respawns them at random heights.
- Detects collision with the player square and produces score pulses plus a game-state FSM (idle/run/crash).
- Sits between the 1 s/frame tick domain logic and the Pintar renderer.
- Generalises the fixed two-car/one-random-car registers to N channels with built-in LFSR, crash detection and restart.

Parameters:
NUM_OBS, 3, number of obstacle channels (1..8)
X_W, 11, X coordinate width
Y_W, 9, Y coordinate width
SCREEN_W, 640, X of obstacle 0 after reset/restart; obstacle i starts at SCREEN_W + i*SPACING
SPACING, 220, horizontal pitch between obstacles; must exceed OBS_W+STEP
STEP, 2, pixels moved per tick (base step)
OBS_W, 40, obstacle width; OBS_H, 60, obstacle height
PLAYER_X, 100, player left column; PLAYER_W, 20; PLAYER_H, 20
Y_MAX, 400, max obstacle top Y
LFSR_SEED, 16'hACE1, non-zero LFSR reset value
SPEEDUP_EVERY, 8, points per speed step (SPEEDUP_EN only)
STEP_MAX, 6, step ceiling (SPEEDUP_EN only)

Ports:
iClk  in  1  system clock
iReset  in  1  asynchronous, active-high reset
iStart  in  1  start/restart request, sampled each clock
iTick  in  1  movement strobe, one clock wide
iPlayerY  in  Y_W  player top Y
oPosX  out  NUM_OBS*X_W  obstacle X, channel i at [i*X_W +: X_W]
oPosY  out  NUM_OBS*Y_W  obstacle top Y, packed the same way
oPaint  out  1  high in RUN and CRASH; renderer enable
oScorePulse  out  1  one-clock pulse per obstacle passed
oCrash  out  1  high while in CRASH
oState  out  2  0=IDLE, 1=RUN, 2=CRASH

Behaviour:
- Reset (async, active-high): state IDLE; X_i = SCREEN_W + i*SPACING; Y_i = Y_MAX>>1; LFSR = LFSR_SEED; oScorePulse=0; oCrash=0; oPaint=0; step=STEP.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every clock in all states. Respawn Y = min(LFSR[Y_W-1:0], Y_MAX).
- IDLE:
  - Positions are held at their initial values.
  - iStart -> RUN next clock. An iTick in the same clock is ignored.
- RUN, on iTick, per channel:
  - If X_i < step: X_i <= X_i + NUM_OBS*SPACING - step and Y_i <= respawn Y. The add keeps spacing uniform.
  - Otherwise X_i <= X_i - step.
  - Updated positions are visible on the next clock.
- Score:
  - Passed_i is true when (X_i+OBS_W) >= PLAYER_X before the tick and < PLAYER_X after it, evaluated at X_W+1 bits.
  - oScorePulse is registered and asserted one clock after the tick that caused the crossing.
  - Spacing constraint guarantees at most one crossing per tick.
- Collision:
  - Evaluated every RUN clock on the registered positions and iPlayerY, all sums at width+1 bits.
  - Overlap_i = X_i < PLAYER_X+PLAYER_W && X_i+OBS_W > PLAYER_X && Y_i < iPlayerY+PLAYER_H && Y_i+OBS_H > iPlayerY.
  - Any overlap -> CRASH next clock and oCrash=1.
  - Crash in the same clock as a score crossing: crash wins and the pulse is suppressed.
- CRASH:
  - Positions frozen; iTick ignored; oPaint stays 1.
  - iStart -> IDLE with positions and Y reloaded to reset values; LFSR not reloaded.
- iStart during RUN is ignored.
- Reset mid-operation aborts immediately to reset values.

Optional Feature:
- Macro SPEEDUP_EN.
  - Defined: internal score counter (8 bit, cleared on restart). Each SPEEDUP_EVERY points, step increments by 1, saturating at STEP_MAX. Restart restores STEP.
  - Undefined: step is the constant STEP and no counter is instantiated.

Test Plan:
- Reset, then hold iStart=0 and pulse iTick 10x -> state IDLE, oPosX={1080,860,640}, all Y=200, oPaint=0.
- Pulse iStart, then 291 ticks with iPlayerY=0 -> X0=58; oScorePulse high exactly one clock after the 291st tick; no crash.
- From start, 321 ticks with iPlayerY=0 -> X0=658, Y0=min(LFSR,400), X1=218, X2=438; spacing stays 220.
- From start, iPlayerY=210 -> after tick 261 (X0=118), oCrash=1 within 2 clocks and state=2; further ticks leave X frozen; no pulse at tick 291.
- In CRASH, pulse iStart -> IDLE, positions reloaded, oCrash=0. Second iStart -> RUN.
- With SPEEDUP_EN, after 8 score pulses -> per-tick displacement becomes 3. Assert iReset mid-RUN -> all outputs at reset values in the same clock.
